// File: rtl/mmc_dfi_cmd_sched.sv
// DFI command scheduler. It arbitrates round-robin across MMC channels and tracks per-bank
// ACT->RD/WR and ACT->ACT timing. A read-tag FIFO routes each returned read burst back to the
// channel that issued it.
// Optional build macro: MGR_DFI_SCH_PERF_CNT_EN adds the issue and stall performance counters.
module mmc_dfi_cmd_sched #(
  parameter int unsigned NUM_CHAN     = 4,
  parameter int unsigned CHAN_W       = 2,
  parameter int unsigned BANK_W       = 2,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned T_RCD        = 3,
  parameter int unsigned T_RC         = 8,
  parameter int unsigned RD_TAG_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_poweron_n,
  input  logic [NUM_CHAN-1:0]        mmc__sch__valid,
  input  logic [2*NUM_CHAN-1:0]      mmc__sch__cmd,
  input  logic [BANK_W*NUM_CHAN-1:0] mmc__sch__bank,
  input  logic [ADDR_W*NUM_CHAN-1:0] mmc__sch__addr,
  output logic [NUM_CHAN-1:0]        sch__mmc__ready,
  output logic                       sch__dfi__cs,
  output logic [1:0]                 sch__dfi__cmd,
  output logic [BANK_W-1:0]          sch__dfi__bank,
  output logic [ADDR_W-1:0]          sch__dfi__addr,
  output logic [CHAN_W-1:0]          sch__dfi__chan,
  input  logic                       dfi__sch__valid,
  output logic                       sch__mmc__rtn_valid,
  output logic [CHAN_W-1:0]          sch__mmc__rtn_chan,
`ifdef MGR_DFI_SCH_PERF_CNT_EN
  output logic [31:0]                sch__perf_issue_cnt,
  output logic [31:0]                sch__perf_stall_cnt,
`endif
  output logic                       sch__tag_underflow
);

  localparam int unsigned NUM_BANKS = 1 << BANK_W;
  localparam int unsigned TAG_W     = (RD_TAG_DEPTH > 1) ? $clog2(RD_TAG_DEPTH) : 1;
  localparam int unsigned TIM_W     = $clog2(T_RC + 1);
  localparam logic [TAG_W:0] TAG_FULL = (TAG_W+1)'(RD_TAG_DEPTH);

  typedef enum logic [1:0] {CmdNop = 2'b00, CmdAct = 2'b01, CmdRd = 2'b10, CmdWr = 2'b11} cmd_e;

  cmd_e              cmd_a  [NUM_CHAN];
  logic [BANK_W-1:0] bank_a [NUM_CHAN];
  logic [ADDR_W-1:0] addr_a [NUM_CHAN];
  logic [NUM_CHAN-1:0] elig;

  logic                grant_vld;
  logic [CHAN_W-1:0]   grant_id;
  logic [CHAN_W-1:0]   arb_idx;
  cmd_e                g_cmd;
  logic [BANK_W-1:0]   g_bank;
  logic                issue;

  logic [NUM_BANKS-1:0] open_q;
  logic [TIM_W-1:0]     rcd_q [NUM_BANKS];
  logic [TIM_W-1:0]     rc_q  [NUM_BANKS];
  logic [CHAN_W-1:0]    ptr_q;

  logic [CHAN_W-1:0] tag_mem_q [RD_TAG_DEPTH];
  logic [TAG_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [TAG_W:0]    tag_cnt_q;
  logic              push, pop;

  // Unpack the flat per-channel request buses.
  always_comb begin
    for (int i = 0; i < NUM_CHAN; i++) begin
      cmd_a[i]  = cmd_e'(mmc__sch__cmd[2*i +: 2]);
      bank_a[i] = mmc__sch__bank[BANK_W*i +: BANK_W];
      addr_a[i] = mmc__sch__addr[ADDR_W*i +: ADDR_W];
    end
  end

  // Per-channel eligibility. Reset gating keeps ready low while the reset input is asserted.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      unique case (cmd_a[i])
        CmdNop: elig[i] = 1'b1;
        CmdAct: elig[i] = (rc_q[bank_a[i]] == '0);
        CmdRd:  elig[i] = open_q[bank_a[i]] && (rcd_q[bank_a[i]] == '0) && (tag_cnt_q < TAG_FULL);
        CmdWr:  elig[i] = open_q[bank_a[i]] && (rcd_q[bank_a[i]] == '0);
        default: elig[i] = 1'b0;
      endcase
      elig[i] = elig[i] & mmc__sch__valid[i] & reset_poweron_n;
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    arb_idx   = '0;
    for (int k = 1; k <= NUM_CHAN; k++) begin
      arb_idx = CHAN_W'((int'(ptr_q) + k) % NUM_CHAN);
      if (!grant_vld && elig[arb_idx]) begin
        grant_vld = 1'b1;
        grant_id  = arb_idx;
      end
    end
  end

  // One-hot grant to the winning channel and decode of the granted request.
  always_comb begin
    sch__mmc__ready = '0;
    if (grant_vld) sch__mmc__ready[grant_id] = 1'b1;
    g_cmd  = cmd_a[grant_id];
    g_bank = bank_a[grant_id];
    issue  = grant_vld && (g_cmd != CmdNop);
    push   = grant_vld && (g_cmd == CmdRd);
    pop    = dfi__sch__valid && (tag_cnt_q != '0);
  end

  // Registered command issue. Idle cycles keep bank/addr/chan from the last command.
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      sch__dfi__cs   <= 1'b0;
      sch__dfi__cmd  <= CmdNop;
      sch__dfi__bank <= '0;
      sch__dfi__addr <= '0;
      sch__dfi__chan <= '0;
      ptr_q          <= CHAN_W'(NUM_CHAN - 1);
    end else begin
      sch__dfi__cs  <= issue;
      sch__dfi__cmd <= issue ? g_cmd : CmdNop;
      if (issue) begin
        sch__dfi__bank <= g_bank;
        sch__dfi__addr <= addr_a[grant_id];
        sch__dfi__chan <= grant_id;
      end
      if (grant_vld) ptr_q <= grant_id;
    end
  end

  // Bank open flags and saturating ACT timing counters.
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      open_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        rcd_q[b] <= '0;
        rc_q[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (grant_vld && (g_cmd == CmdAct) && (g_bank == BANK_W'(b))) begin
          open_q[b] <= 1'b1;
          rcd_q[b]  <= TIM_W'(T_RCD - 1);
          rc_q[b]   <= TIM_W'(T_RC - 1);
        end else begin
          if (rcd_q[b] != '0) rcd_q[b] <= rcd_q[b] - 1'b1;
          if (rc_q[b] != '0)  rc_q[b]  <= rc_q[b] - 1'b1;
        end
      end
    end
  end

  // Read-tag FIFO. A pop on an empty FIFO only raises the sticky underflow flag.
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      for (int t = 0; t < RD_TAG_DEPTH; t++) tag_mem_q[t] <= '0;
      wr_ptr_q            <= '0;
      rd_ptr_q            <= '0;
      tag_cnt_q           <= '0;
      sch__mmc__rtn_valid <= 1'b0;
      sch__mmc__rtn_chan  <= '0;
      sch__tag_underflow  <= 1'b0;
    end else begin
      if (push) begin
        tag_mem_q[wr_ptr_q] <= grant_id;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q           <= rd_ptr_q + 1'b1;
        sch__mmc__rtn_chan <= tag_mem_q[rd_ptr_q];
      end
      if (push && !pop)      tag_cnt_q <= tag_cnt_q + 1'b1;
      else if (!push && pop) tag_cnt_q <= tag_cnt_q - 1'b1;
      sch__mmc__rtn_valid <= pop;
      if (dfi__sch__valid && (tag_cnt_q == '0)) sch__tag_underflow <= 1'b1;
    end
  end

`ifdef MGR_DFI_SCH_PERF_CNT_EN
  // Issue and stall counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      sch__perf_issue_cnt <= '0;
      sch__perf_stall_cnt <= '0;
    end else begin
      if (issue) sch__perf_issue_cnt <= sch__perf_issue_cnt + 32'd1;
      if ((|mmc__sch__valid) && !grant_vld) sch__perf_stall_cnt <= sch__perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mmc_dfi_cmd_sched.sv
// Bench for mmc_dfi_cmd_sched. It applies directed vector tables and hand-written sequences,
// then runs randomized traffic against a timestamp/queue reference model.
module tb_mmc_dfi_cmd_sched;

  localparam int NUM_CHAN = 4;
  localparam int T_RCD    = 3;
  localparam int T_RC     = 8;
  localparam int DEPTH    = 8;
  localparam logic [47:0] ADDR_PAT = {12'h3c3, 12'h2b2, 12'h1a1, 12'h090};

  logic        clk = 1'b0;
  logic        reset_poweron_n = 1'b0;
  logic [3:0]  valid = '0;
  logic [7:0]  cmd = '0;
  logic [7:0]  bank = '0;
  logic [47:0] addr = '0;
  logic        dfi = 1'b0;
  logic [3:0]  ready;
  logic        cs;
  logic [1:0]  dcmd, dbank, dchan, rtn_chan;
  logic [11:0] daddr;
  logic        rtn_valid, underflow;
`ifdef MGR_DFI_SCH_PERF_CNT_EN
  logic [31:0] perf_issue, perf_stall;
`endif

  mmc_dfi_cmd_sched dut (
    .clk                 (clk),
    .reset_poweron_n     (reset_poweron_n),
    .mmc__sch__valid     (valid),
    .mmc__sch__cmd       (cmd),
    .mmc__sch__bank      (bank),
    .mmc__sch__addr      (addr),
    .sch__mmc__ready     (ready),
    .sch__dfi__cs        (cs),
    .sch__dfi__cmd       (dcmd),
    .sch__dfi__bank      (dbank),
    .sch__dfi__addr      (daddr),
    .sch__dfi__chan      (dchan),
    .dfi__sch__valid     (dfi),
    .sch__mmc__rtn_valid (rtn_valid),
    .sch__mmc__rtn_chan  (rtn_chan),
`ifdef MGR_DFI_SCH_PERF_CNT_EN
    .sch__perf_issue_cnt (perf_issue),
    .sch__perf_stall_cnt (perf_stall),
`endif
    .sch__tag_underflow  (underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: last-ACT timestamps per bank, open flags, a tag queue and rr pointer.
  int  cyc;
  int  last_act [4];
  bit  open_m [4];
  int  ptr_m;
  int  tagq [$];
  logic       e_cs, e_rv, e_uf;
  logic [1:0] e_cmd, e_bank, e_chan, e_rchan;
  logic [11:0] e_addr;

  // Values observed in the most recent step.
  logic [3:0] obs_ready;
  logic       obs_cs, obs_rv;
  logic [1:0] obs_cmd, obs_bank, obs_chan, obs_rchan;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    ptr_m = NUM_CHAN - 1;
    for (int b = 0; b < 4; b++) begin
      open_m[b]   = 1'b0;
      last_act[b] = -1000;
    end
    tagq.delete();
    e_cs = 0; e_rv = 0; e_uf = 0; e_cmd = 0; e_bank = 0; e_chan = 0; e_rchan = 0; e_addr = 0;
    cyc = 0;
  endfunction

  function automatic bit m_elig(input logic vv, input logic [1:0] cc, input int bb);
    int age;
    age = cyc - last_act[bb];
    if (!vv) return 1'b0;
    case (cc)
      2'b00:   return 1'b1;
      2'b01:   return age >= T_RC;
      2'b10:   return open_m[bb] && age >= T_RCD && tagq.size() < DEPTH;
      default: return open_m[bb] && age >= T_RCD;
    endcase
  endfunction

  function automatic int m_pick(input logic [3:0] v, input logic [7:0] c, input logic [7:0] b);
    for (int k = 1; k <= NUM_CHAN; k++) begin
      int ch;
      ch = (ptr_m + k) % NUM_CHAN;
      if (m_elig(v[ch], c[2*ch +: 2], int'(b[2*ch +: 2]))) return ch;
    end
    return -1;
  endfunction

  function automatic void m_update(input int g, input logic [7:0] c, input logic [7:0] b,
                                   input logic [47:0] a, input logic d);
    logic [1:0] gc, gb;
    int pre;
    pre = tagq.size();
    e_rv = 1'b0;
    if (d) begin
      if (pre > 0) begin
        e_rv    = 1'b1;
        e_rchan = 2'(tagq.pop_front());
      end else begin
        e_uf = 1'b1;
      end
    end
    e_cs  = 1'b0;
    e_cmd = 2'b00;
    if (g >= 0) begin
      gc    = c[2*g +: 2];
      gb    = b[2*g +: 2];
      ptr_m = g;
      if (gc == 2'b01) begin
        last_act[gb] = cyc;
        open_m[gb]   = 1'b1;
      end
      if (gc == 2'b10) tagq.push_back(g);
      if (gc != 2'b00) begin
        e_cs = 1'b1; e_cmd = gc; e_bank = gb; e_chan = 2'(g); e_addr = a[12*g +: 12];
      end
    end
    cyc++;
  endfunction

  // One clock: drive at negedge, check combinational and registered outputs, advance model.
  task automatic step(input logic [3:0] v, input logic [7:0] c, input logic [7:0] b,
                      input logic [47:0] a, input logic d);
    int g;
    logic [3:0] er;
    @(negedge clk);
    valid = v; cmd = c; bank = b; addr = a; dfi = d;
    #1;
    g  = m_pick(v, c, b);
    er = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("m_ready", ready, er);
    chk("m_cs", cs, e_cs);
    chk("m_cmd", dcmd, e_cmd);
    chk("m_bank", dbank, e_bank);
    chk("m_addr", daddr, e_addr);
    chk("m_chan", dchan, e_chan);
    chk("m_rtn_valid", rtn_valid, e_rv);
    if (e_rv) chk("m_rtn_chan", rtn_chan, e_rchan);
    chk("m_underflow", underflow, e_uf);
    obs_ready = ready; obs_cs = cs; obs_cmd = dcmd; obs_bank = dbank; obs_chan = dchan;
    obs_rv = rtn_valid; obs_rchan = rtn_chan;
    @(posedge clk);
    m_update(g, c, b, a, d);
  endtask

  // Asserts reset mid-cycle with an ACT request pending; every output must drop at once.
  task automatic do_reset();
    @(negedge clk);
    valid = 4'b0010; cmd = 8'b0000_0100; bank = 8'b0000_1100; dfi = 1'b0;
    #2 reset_poweron_n = 1'b0;
    #1;
    chk("rst_ready", ready, 4'b0);
    chk("rst_cs", cs, 1'b0);
    chk("rst_cmd", dcmd, 2'b0);
    chk("rst_bank", dbank, 2'b0);
    chk("rst_addr", daddr, 12'b0);
    chk("rst_chan", dchan, 2'b0);
    chk("rst_rtn_valid", rtn_valid, 1'b0);
    chk("rst_rtn_chan", rtn_chan, 2'b0);
    chk("rst_underflow", underflow, 1'b0);
    valid = '0;
    m_reset();
    @(negedge clk);
    reset_poweron_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] v;
    logic [7:0] c;
    logic [7:0] b;
    logic [3:0] er;
    logic       ecs;
    logic [1:0] ecmd;
    logic [1:0] ebank;
    logic [1:0] echan;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input bit rst, input logic [3:0] v, input logic [7:0] c,
                              input logic [7:0] b, input logic [3:0] er, input logic ecs,
                              input logic [1:0] ecmd, input logic [1:0] ebank,
                              input logic [1:0] echan);
    vec_t r;
    r.rst = rst; r.v = v; r.c = c; r.b = b; r.er = er;
    r.ecs = ecs; r.ecmd = ecmd; r.ebank = ebank; r.echan = echan;
    tbl.push_back(r);
  endfunction

  initial begin
    int n_gr;
    m_reset();

    // Four channels ACT banks 0..3 together: grants in order ch0..ch3, issue one cycle later.
    add(1, 4'b1111, 8'b01010101, 8'b11100100, 4'b0001, 0, 2'd0, 2'd0, 2'd0);
    add(0, 4'b1110, 8'b01010101, 8'b11100100, 4'b0010, 1, 2'd1, 2'd0, 2'd0);
    add(0, 4'b1100, 8'b01010101, 8'b11100100, 4'b0100, 1, 2'd1, 2'd1, 2'd1);
    add(0, 4'b1000, 8'b01010101, 8'b11100100, 4'b1000, 1, 2'd1, 2'd2, 2'd2);
    add(0, 4'b0000, 8'b01010101, 8'b11100100, 4'b0000, 1, 2'd1, 2'd3, 2'd3);
    add(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0000, 0, 2'd0, 2'd3, 2'd3);
    // ch1 ACT bank2, then RD bank2 held: ready 3 cycles after the ACT handshake.
    add(1, 4'b0010, 8'b00000100, 8'b00001000, 4'b0010, 0, 2'd0, 2'd0, 2'd0);
    add(0, 4'b0010, 8'b00001000, 8'b00001000, 4'b0000, 1, 2'd1, 2'd2, 2'd1);
    add(0, 4'b0010, 8'b00001000, 8'b00001000, 4'b0000, 0, 2'd0, 2'd2, 2'd1);
    add(0, 4'b0010, 8'b00001000, 8'b00001000, 4'b0010, 0, 2'd0, 2'd2, 2'd1);
    add(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0000, 1, 2'd2, 2'd2, 2'd1);
    // ch0 RD to closed bank1 waits while ch2 opens it.
    add(1, 4'b0101, 8'b00010010, 8'b00010001, 4'b0100, 0, 2'd0, 2'd0, 2'd0);
    add(0, 4'b0001, 8'b00010010, 8'b00010001, 4'b0000, 1, 2'd1, 2'd1, 2'd2);
    add(0, 4'b0001, 8'b00010010, 8'b00010001, 4'b0000, 0, 2'd0, 2'd1, 2'd2);
    add(0, 4'b0001, 8'b00010010, 8'b00010001, 4'b0001, 0, 2'd0, 2'd1, 2'd2);
    add(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0000, 1, 2'd2, 2'd1, 2'd0);
    // Back-to-back ACT bank0: second grant exactly T_RC cycles after the first.
    add(1, 4'b0001, 8'b00000001, 8'b00000000, 4'b0001, 0, 2'd0, 2'd0, 2'd0);
    add(0, 4'b0001, 8'b00000001, 8'b00000000, 4'b0000, 1, 2'd1, 2'd0, 2'd0);
    for (int i = 2; i < T_RC; i++)
      add(0, 4'b0001, 8'b00000001, 8'b00000000, 4'b0000, 0, 2'd0, 2'd0, 2'd0);
    add(0, 4'b0001, 8'b00000001, 8'b00000000, 4'b0001, 0, 2'd0, 2'd0, 2'd0);
    add(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0000, 1, 2'd1, 2'd0, 2'd0);

    repeat (2) @(negedge clk);
    reset_poweron_n = 1'b1;
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].v, tbl[i].c, tbl[i].b, ADDR_PAT, 1'b0);
      chk($sformatf("row%0d_ready", i), obs_ready, tbl[i].er);
      chk($sformatf("row%0d_cs", i), obs_cs, tbl[i].ecs);
      chk($sformatf("row%0d_cmd", i), obs_cmd, tbl[i].ecmd);
      chk($sformatf("row%0d_bank", i), obs_bank, tbl[i].ebank);
      chk($sformatf("row%0d_chan", i), obs_chan, tbl[i].echan);
    end

    // Tag FIFO full: 8 RDs from ch3 go, the 9th waits until one return pops a tag.
    do_reset();
    step(4'b1000, 8'b01000000, 8'h00, ADDR_PAT, 1'b0);
    n_gr = 0;
    for (int i = 0; i < 11; i++) begin
      step(4'b1000, 8'b10000000, 8'h00, ADDR_PAT, 1'b0);
      if (obs_ready[3]) n_gr++;
    end
    chk("full_grants", n_gr, DEPTH);
    chk("full_9th_stall", obs_ready, 4'b0000);
    step(4'b1000, 8'b10000000, 8'h00, ADDR_PAT, 1'b1);
    chk("full_pop_cycle_ready", obs_ready, 4'b0000);
    step(4'b1000, 8'b10000000, 8'h00, ADDR_PAT, 1'b0);
    chk("full_rtn_valid", obs_rv, 1'b1);
    chk("full_rtn_chan", obs_rchan, 2'd3);
    chk("full_9th_ready", obs_ready, 4'b1000);

    // Underflow, then reset with two tags outstanding, then the FIFO must be empty.
    do_reset();
    step(4'b0000, 8'h00, 8'h00, ADDR_PAT, 1'b1);
    step(4'b0000, 8'h00, 8'h00, ADDR_PAT, 1'b0);
    chk("uf_rtn_valid", obs_rv, 1'b0);
    chk("uf_flag", underflow, 1'b1);
    step(4'b0001, 8'b00000001, 8'h00, ADDR_PAT, 1'b0);
    step(4'b0000, 8'h00, 8'h00, ADDR_PAT, 1'b0);
    step(4'b0000, 8'h00, 8'h00, ADDR_PAT, 1'b0);
    step(4'b0001, 8'b00000010, 8'h00, ADDR_PAT, 1'b0);
    step(4'b0001, 8'b00000010, 8'h00, ADDR_PAT, 1'b0);
    chk("uf_tags_out", tagq.size(), 2);
    do_reset();
    step(4'b0000, 8'h00, 8'h00, ADDR_PAT, 1'b1);
    step(4'b0000, 8'h00, 8'h00, ADDR_PAT, 1'b0);
    chk("post_rst_rtn_valid", obs_rv, 1'b0);
    chk("post_rst_underflow", underflow, 1'b1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom), 8'($urandom), 8'($urandom), 48'({$urandom, $urandom}),
           ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
